qtable_update_scheduler: RTL and testbench
==========================================

QTABLE_UPDATE_SCHEDULER -- requirements
Module: qtable_update_scheduler

Interface
REQ-001 SHALL have parameters: WORD_WIDTH, default 16, width of every packet field; DEPTH, default 4, packet FIFO entries (power of 2); TIMEOUT, default 64, maximum WAIT cycles.
REQ-002 SHALL provide ports as follows, each "name  direction  width  meaning".
REQ-002a clk  in  1  single clock; all state changes on rising edge.
REQ-002b rst  in  1  synchronous reset, active-high.
REQ-003 pkt_valid  in  1  receiver offers a packet.
REQ-004 pkt_ready  out  1  FIFO can accept; equals !full; 0 while rst high.
REQ-005 pkt_srcID, pkt_hops, pkt_clusterID, pkt_energy, pkt_qvalue  in  WORD_WIDTH each  packet fields (energy, qvalue Q-format passthrough).
REQ-006 pkt_type  in  3  packet type; 3'b111 reserved.
REQ-007 upd_en  out  1  one-cycle start pulse to the Q-table update engine.
REQ-008 upd_srcID, upd_hops, upd_clusterID, upd_energy, upd_qvalue  out  WORD_WIDTH each  FIFO-head fields to the engine.
REQ-009 upd_type  out  3  FIFO-head type.
REQ-010 upd_done  in  1  engine finished; sampled only in WAIT.
REQ-011 rd_req  in  1  next-hop selector requests neighbor-table read access.
REQ-012 rd_gnt  out  1  read access granted; engine is idle while high.
REQ-013 busy  out  1  FSM not in IDLE.
REQ-014 drop_count  out  16  reserved-type packets discarded, saturating.
REQ-015 timeout_err  out  1  sticky; set on any engine timeout.

Function
REQ-016 Handshake: push when pkt_valid && pkt_ready; fields sampled that edge; no push when full (backpressure, not drop).
REQ-017 Push with pkt_type==3'b111 SHALL be accepted but not stored; drop_count+1, saturates at 16'hFFFF.
REQ-018 FIFO: circular, wrap-around pointers, count 0..DEPTH; simultaneous push and pop SHALL keep count unchanged; push into empty FIFO SHALL not bypass storage.
REQ-019 upd_* fields SHALL reflect FIFO head and stay stable from ISSUE through pop.
REQ-020 FSM states IDLE, ISSUE, WAIT, READ.
REQ-021 IDLE: if FIFO non-empty and rd_req both pending, grant to the requester not served last (rr bit, reset favours update); else serve whichever is pending; update -> ISSUE, read -> READ.
REQ-022 ISSUE: upd_en=1 for exactly this one cycle; next state WAIT; timer cleared.
REQ-023 WAIT: upd_done=1 -> pop head, IDLE; else timer+1; timer reaching TIMEOUT -> pop head, set timeout_err, IDLE.
REQ-024 READ: rd_gnt=1 for every cycle in READ; rd_req low -> IDLE next edge; no upd_en while in READ.
REQ-025 rd_req arriving during ISSUE/WAIT SHALL wait; upd_done outside WAIT SHALL be ignored.
REQ-026 Latency: packet pushed into empty FIFO with FSM IDLE and rd_req low -> upd_en high on the 2nd rising edge after the push edge.
REQ-027 busy SHALL be 1 in ISSUE, WAIT, READ.

Reset
REQ-028 rst high at an edge: FSM IDLE, FIFO empty, pointers 0, timer 0, rr favours update, drop_count 0, timeout_err 0; upd_en, rd_gnt, busy, upd_* all 0.
REQ-029 Reset mid-WAIT or mid-READ SHALL abort immediately; in-flight packet discarded; no upd_en pulse after release until a new push.

Verification
REQ-030 Single packet srcID=1, hops=2, cluster=2, energy=16'h8000, qvalue=16'h3000, type=3'b101; done 5 cycles after upd_en -> one upd_en pulse, upd_* match, busy drops the cycle after done, FIFO empty.
REQ-031 Push 5 packets back-to-back, engine idle-stalled -> pkt_ready 0 after 4th accepted, 5th held; pulse done -> pkt_ready 1, 5th accepted; upd_en order srcID 1..5.
REQ-032 Push type 3'b111 then type 3'b101 srcID=17 -> drop_count=1, single upd_en with srcID=17.
REQ-033 FIFO non-empty and rd_req high together in IDLE from reset -> update served first; after done, rd_gnt; rd_req held 3 cycles -> rd_gnt 3 cycles, then next packet issues.
REQ-034 Never assert upd_done, TIMEOUT=64 -> timeout_err 1 exactly 64 cycles after WAIT entry; head popped; next packet issues normally.
REQ-035 Assert rst during WAIT -> next edge all outputs 0, FIFO empty, no later upd_en without new push.

Source files
------------

// File: rtl/qtable_update_scheduler.sv
// Packet FIFO plus arbiter that feeds a Q-table update engine one packet at a time
// and time-shares the table with the next-hop selector's read requests.
module qtable_update_scheduler #(
  parameter int WORD_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pkt_valid,
  output logic                  pkt_ready,
  input  logic [WORD_WIDTH-1:0] pkt_srcID,
  input  logic [WORD_WIDTH-1:0] pkt_hops,
  input  logic [WORD_WIDTH-1:0] pkt_clusterID,
  input  logic [WORD_WIDTH-1:0] pkt_energy,
  input  logic [WORD_WIDTH-1:0] pkt_qvalue,
  input  logic [2:0]            pkt_type,
  output logic                  upd_en,
  output logic [WORD_WIDTH-1:0] upd_srcID,
  output logic [WORD_WIDTH-1:0] upd_hops,
  output logic [WORD_WIDTH-1:0] upd_clusterID,
  output logic [WORD_WIDTH-1:0] upd_energy,
  output logic [WORD_WIDTH-1:0] upd_qvalue,
  output logic [2:0]            upd_type,
  input  logic                  upd_done,
  input  logic                  rd_req,
  output logic                  rd_gnt,
  output logic                  busy,
  output logic [15:0]           drop_count,
  output logic                  timeout_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [PTR_W-1:0] PTR_LAST      = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL      = CNT_W'(DEPTH);
  localparam logic [TMR_W-1:0] TIMER_LAST    = TMR_W'(TIMEOUT - 1);
  localparam logic [2:0]       RESERVED_TYPE = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    READ
  } schedState_e;

  typedef struct packed {
    logic [2:0]            pType;
    logic [WORD_WIDTH-1:0] qvalue;
    logic [WORD_WIDTH-1:0] energy;
    logic [WORD_WIDTH-1:0] clusterID;
    logic [WORD_WIDTH-1:0] hops;
    logic [WORD_WIDTH-1:0] srcID;
  } entry_t;

  function automatic logic [15:0] satInc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  entry_t           mem [DEPTH];
  entry_t           entryIn;
  entry_t           headView;
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             pushAcc;
  logic             storeEn;
  logic             dropEn;
  logic             popEn;

  schedState_e      state;
  schedState_e      stateNxt;
  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timerNxt;
  logic             favourRead;
  logic             favourReadNxt;
  logic             timeoutSet;
  logic [15:0]      dropCount;
  logic             timeoutErr;

  assign full      = (count == CNT_FULL);
  assign empty     = (count == '0);
  assign pkt_ready = !full && !rst;
  assign pushAcc   = pkt_valid && pkt_ready;
  assign storeEn   = pushAcc && (pkt_type != RESERVED_TYPE);
  assign dropEn    = pushAcc && (pkt_type == RESERVED_TYPE);

  assign entryIn = '{
    pType:     pkt_type,
    qvalue:    pkt_qvalue,
    energy:    pkt_energy,
    clusterID: pkt_clusterID,
    hops:      pkt_hops,
    srcID:     pkt_srcID
  };

  // Storage holds data only; occupancy lives in count so reset needs no array clear.
  always_ff @(posedge clk) begin
    if (storeEn) begin
      mem[wrPtr] <= entryIn;
    end
  end

  always_comb begin
    headView = '0;
    if (!empty) begin
      headView = mem[rdPtr];
    end
  end

  assign upd_srcID     = headView.srcID;
  assign upd_hops      = headView.hops;
  assign upd_clusterID = headView.clusterID;
  assign upd_energy    = headView.energy;
  assign upd_qvalue    = headView.qvalue;
  assign upd_type      = headView.pType;

  always_comb begin
    stateNxt      = state;
    timerNxt      = timer;
    favourReadNxt = favourRead;
    popEn         = 1'b0;
    timeoutSet    = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && (!rd_req || !favourRead)) begin
          stateNxt      = ISSUE;
          favourReadNxt = 1'b1;
        end else if (rd_req) begin
          stateNxt      = READ;
          favourReadNxt = 1'b0;
        end
      end
      ISSUE: begin
        stateNxt = WAIT;
        timerNxt = '0;
      end
      WAIT: begin
        if (upd_done) begin
          popEn    = 1'b1;
          stateNxt = IDLE;
        end else if (timer == TIMER_LAST) begin
          // The stalled packet is abandoned so the queue keeps moving.
          popEn      = 1'b1;
          timeoutSet = 1'b1;
          stateNxt   = IDLE;
        end else begin
          timerNxt = timer + TMR_W'(1);
        end
      end
      READ: begin
        if (!rd_req) begin
          stateNxt = IDLE;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      favourRead <= 1'b0;
      wrPtr      <= '0;
      rdPtr      <= '0;
      count      <= '0;
      dropCount  <= '0;
      timeoutErr <= 1'b0;
    end else begin
      state      <= stateNxt;
      timer      <= timerNxt;
      favourRead <= favourReadNxt;
      if (storeEn) begin
        wrPtr <= nextPtr(wrPtr);
      end
      if (popEn) begin
        rdPtr <= nextPtr(rdPtr);
      end
      case ({storeEn, popEn})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (dropEn) begin
        dropCount <= satInc16(dropCount);
      end
      if (timeoutSet) begin
        timeoutErr <= 1'b1;
      end
    end
  end

  assign upd_en      = (state == ISSUE);
  assign rd_gnt      = (state == READ);
  assign busy        = (state != IDLE);
  assign drop_count  = dropCount;
  assign timeout_err = timeoutErr;

endmodule

// File: tb/tb_qtable_update_scheduler.sv
// Directed bench for qtable_update_scheduler: vector table for single packets,
// hand sequences for backpressure, arbitration, timeout and reset abort.
module tb_qtable_update_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [15:0] pkt_srcID, pkt_hops, pkt_clusterID, pkt_energy, pkt_qvalue;
  logic [2:0]  pkt_type;
  logic        upd_en;
  logic [15:0] upd_srcID, upd_hops, upd_clusterID, upd_energy, upd_qvalue;
  logic [2:0]  upd_type;
  logic        upd_done;
  logic        rd_req;
  logic        rd_gnt;
  logic        busy;
  logic [15:0] drop_count;
  logic        timeout_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  qtable_update_scheduler #(
    .WORD_WIDTH(16),
    .DEPTH(4),
    .TIMEOUT(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pkt_valid(pkt_valid),
    .pkt_ready(pkt_ready),
    .pkt_srcID(pkt_srcID),
    .pkt_hops(pkt_hops),
    .pkt_clusterID(pkt_clusterID),
    .pkt_energy(pkt_energy),
    .pkt_qvalue(pkt_qvalue),
    .pkt_type(pkt_type),
    .upd_en(upd_en),
    .upd_srcID(upd_srcID),
    .upd_hops(upd_hops),
    .upd_clusterID(upd_clusterID),
    .upd_energy(upd_energy),
    .upd_qvalue(upd_qvalue),
    .upd_type(upd_type),
    .upd_done(upd_done),
    .rd_req(rd_req),
    .rd_gnt(rd_gnt),
    .busy(busy),
    .drop_count(drop_count),
    .timeout_err(timeout_err)
  );

  typedef struct {
    logic [15:0] srcID;
    logic [15:0] hops;
    logic [15:0] clusterID;
    logic [15:0] energy;
    logic [15:0] qvalue;
    logic [2:0]  pType;
    int          doneDelay;
    bit          expUpd;
    logic [15:0] expDrop;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic nstep(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drivePkt(input logic [15:0] s, input logic [15:0] h, input logic [15:0] c,
                          input logic [15:0] e, input logic [15:0] q, input logic [2:0] t);
    pkt_valid     = 1'b1;
    pkt_srcID     = s;
    pkt_hops      = h;
    pkt_clusterID = c;
    pkt_energy    = e;
    pkt_qvalue    = q;
    pkt_type      = t;
  endtask

  task automatic waitUpdEn(input logic [15:0] expSrc, input string name);
    int n = 0;
    while (!upd_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_upd_en"}, upd_en, 1);
    check({name, "_srcID"}, upd_srcID, expSrc);
  endtask

  // Called with the FSM in ISSUE: moves to WAIT, then completes the update.
  task automatic pulseDone();
    nstep(1);
    upd_done = 1'b1;
    nstep(1);
    upd_done = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    nstep(1);
    rst = 1'b0;
    nstep(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'd1,     16'd2,     16'd2,     16'h8000, 16'h3000, 3'b101, 5, 1'b1, 16'd0};
    vecs[1] = '{16'd9,     16'd9,     16'd9,     16'd9,    16'd9,    3'b111, 0, 1'b0, 16'd1};
    vecs[2] = '{16'd17,    16'd3,     16'd4,     16'h1234, 16'h0FFF, 3'b101, 2, 1'b1, 16'd1};
    vecs[3] = '{16'hFFFF,  16'hA5A5,  16'h5A5A,  16'h7FFF, 16'h8001, 3'b000, 1, 1'b1, 16'd1};
    vecs[4] = '{16'd0,     16'd1,     16'd0,     16'hFFFF, 16'd0,    3'b110, 3, 1'b1, 16'd1};

    rst = 1'b1;
    pkt_valid = 1'b0;
    pkt_srcID = '0; pkt_hops = '0; pkt_clusterID = '0; pkt_energy = '0; pkt_qvalue = '0;
    pkt_type = '0;
    upd_done = 1'b0;
    rd_req = 1'b0;

    // Reset state, sampled while rst is still high.
    nstep(2);
    check("rst_pkt_ready", pkt_ready, 0);
    check("rst_upd_en", upd_en, 0);
    check("rst_rd_gnt", rd_gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_drop_count", drop_count, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_upd_srcID", upd_srcID, 0);
    check("rst_upd_type", upd_type, 0);
    rst = 1'b0;
    nstep(1);
    check("post_rst_ready", pkt_ready, 1);

    // Single-packet vectors into an empty FIFO with the FSM idle.
    for (int i = 0; i < 5; i++) begin
      drivePkt(vecs[i].srcID, vecs[i].hops, vecs[i].clusterID,
               vecs[i].energy, vecs[i].qvalue, vecs[i].pType);
      check($sformatf("v%0d_ready", i), pkt_ready, 1);
      nstep(1);
      pkt_valid = 1'b0;
      check($sformatf("v%0d_no_early_upd_en", i), upd_en, 0);
      nstep(1);
      check($sformatf("v%0d_upd_en", i), upd_en, vecs[i].expUpd);
      check($sformatf("v%0d_drop_count", i), drop_count, vecs[i].expDrop);
      if (vecs[i].expUpd) begin
        check($sformatf("v%0d_srcID", i), upd_srcID, vecs[i].srcID);
        check($sformatf("v%0d_hops", i), upd_hops, vecs[i].hops);
        check($sformatf("v%0d_cluster", i), upd_clusterID, vecs[i].clusterID);
        check($sformatf("v%0d_energy", i), upd_energy, vecs[i].energy);
        check($sformatf("v%0d_qvalue", i), upd_qvalue, vecs[i].qvalue);
        check($sformatf("v%0d_type", i), upd_type, vecs[i].pType);
        check($sformatf("v%0d_busy", i), busy, 1);
        for (int k = 0; k < vecs[i].doneDelay; k++) begin
          nstep(1);
          check($sformatf("v%0d_wait_upd_en", i), upd_en, 0);
          check($sformatf("v%0d_wait_srcID", i), upd_srcID, vecs[i].srcID);
        end
        upd_done = 1'b1;
        nstep(1);
        upd_done = 1'b0;
        check($sformatf("v%0d_busy_after_done", i), busy, 0);
        check($sformatf("v%0d_ready_after_done", i), pkt_ready, 1);
        nstep(2);
        check($sformatf("v%0d_no_reissue", i), upd_en, 0);
      end else begin
        check($sformatf("v%0d_drop_busy", i), busy, 0);
        nstep(1);
        check($sformatf("v%0d_drop_no_upd_en", i), upd_en, 0);
      end
    end

    // Backpressure: four packets fill the FIFO, the fifth waits for a pop.
    for (int i = 1; i <= 4; i++) begin
      drivePkt(16'(i), 16'd0, 16'd0, 16'd0, 16'd0, 3'b101);
      check($sformatf("bp_ready_%0d", i), pkt_ready, 1);
      nstep(1);
    end
    drivePkt(16'd5, 16'd0, 16'd0, 16'd0, 16'd0, 3'b101);
    check("bp_full_ready", pkt_ready, 0);
    check("bp_busy", busy, 1);
    nstep(2);
    check("bp_still_full", pkt_ready, 0);
    check("bp_head_stable", upd_srcID, 1);
    upd_done = 1'b1;
    nstep(1);
    upd_done = 1'b0;
    check("bp_ready_after_pop", pkt_ready, 1);
    nstep(1);
    pkt_valid = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      waitUpdEn(16'(k), $sformatf("bp_order_%0d", k));
      pulseDone();
    end
    nstep(1);
    check("bp_drained_busy", busy, 0);
    check("bp_drained_ready", pkt_ready, 1);

    // Arbitration from reset: update wins first, then the read, then the next update.
    doReset();
    drivePkt(16'h21, 16'd0, 16'd0, 16'd0, 16'd0, 3'b101);
    nstep(1);
    drivePkt(16'h22, 16'd0, 16'd0, 16'd0, 16'd0, 3'b101);
    rd_req = 1'b1;
    nstep(1);
    pkt_valid = 1'b0;
    check("arb_first_upd_en", upd_en, 1);
    check("arb_first_srcID", upd_srcID, 16'h21);
    check("arb_first_rd_gnt", rd_gnt, 0);
    nstep(1);
    check("arb_wait_rd_gnt", rd_gnt, 0);
    upd_done = 1'b1;
    nstep(1);
    upd_done = 1'b0;
    check("arb_idle_rd_gnt", rd_gnt, 0);
    check("arb_idle_busy", busy, 0);
    for (int k = 0; k < 3; k++) begin
      nstep(1);
      check($sformatf("arb_rd_gnt_%0d", k), rd_gnt, 1);
      check($sformatf("arb_read_upd_en_%0d", k), upd_en, 0);
      check($sformatf("arb_read_busy_%0d", k), busy, 1);
    end
    rd_req = 1'b0;
    nstep(1);
    check("arb_read_released", rd_gnt, 0);
    check("arb_read_released_upd_en", upd_en, 0);
    nstep(1);
    check("arb_second_upd_en", upd_en, 1);
    check("arb_second_srcID", upd_srcID, 16'h22);
    pulseDone();

    // Engine timeout: no done, error after exactly TIMEOUT cycles in WAIT.
    nstep(1);
    drivePkt(16'h31, 16'd0, 16'd0, 16'd0, 16'd0, 3'b101);
    nstep(1);
    drivePkt(16'h32, 16'd0, 16'd0, 16'd0, 16'd0, 3'b101);
    nstep(1);
    pkt_valid = 1'b0;
    check("to_upd_en", upd_en, 1);
    check("to_srcID", upd_srcID, 16'h31);
    nstep(1);
    nstep(63);
    check("to_err_before", timeout_err, 0);
    check("to_busy_before", busy, 1);
    nstep(1);
    check("to_err_at_64", timeout_err, 1);
    check("to_busy_after", busy, 0);
    nstep(1);
    check("to_next_upd_en", upd_en, 1);
    check("to_next_srcID", upd_srcID, 16'h32);
    pulseDone();
    check("to_err_sticky", timeout_err, 1);

    // Reset during WAIT aborts the in-flight packet and empties the FIFO.
    nstep(1);
    drivePkt(16'h41, 16'd0, 16'd0, 16'd0, 16'd0, 3'b101);
    nstep(1);
    drivePkt(16'h42, 16'd0, 16'd0, 16'd0, 16'd0, 3'b101);
    nstep(1);
    pkt_valid = 1'b0;
    nstep(3);
    check("rw_busy_before", busy, 1);
    rst = 1'b1;
    nstep(1);
    check("rw_upd_en", upd_en, 0);
    check("rw_rd_gnt", rd_gnt, 0);
    check("rw_busy", busy, 0);
    check("rw_drop_count", drop_count, 0);
    check("rw_timeout_err", timeout_err, 0);
    check("rw_upd_srcID", upd_srcID, 0);
    check("rw_pkt_ready", pkt_ready, 0);
    rst = 1'b0;
    begin
      int seen = 0;
      for (int k = 0; k < 10; k++) begin
        nstep(1);
        if (k == 2) upd_done = 1'b1;
        if (k == 3) upd_done = 1'b0;
        if (upd_en || busy) seen++;
      end
      check("rw_no_upd_after_release", seen, 0);
    end
    check("rw_ready_after_release", pkt_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
